// File: rtl/asip_stream_pkg.sv
// Shared types and constants for the result stream reader.
package asip_stream_pkg;

  // Transfer sequencing states
  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND_HI,
    SEND_LO,
    DONE
  } stream_state_t;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 2;

endpackage : asip_stream_pkg

// File: rtl/result_stream_reader_if.sv
// Memory read port plus outbound byte stream, bundled for the reader.
interface result_stream_reader_if
  import asip_stream_pkg::*;
#(
  parameter int registerSize = 16,
  parameter int addrWidth    = 16
) ();

  logic                    memRdEn;
  logic [addrWidth-1:0]    memAddr;
  logic [registerSize-1:0] memRdData;
  logic                    outValid;
  logic                    outReady;
  logic [BYTE_W-1:0]       outData;

  // Reader side: drives the read strobe/address and the byte stream
  modport master (
    output memRdEn, memAddr, outValid, outData,
    input  memRdData, outReady
  );

  // Memory/sink side
  modport slave (
    input  memRdEn, memAddr, outValid, outData,
    output memRdData, outReady
  );

endinterface : result_stream_reader_if

// File: rtl/result_stream_reader_serializer.sv
// Holds one memory word and presents it as two bytes, MSB first.
module word_byte_serializer
  import asip_stream_pkg::*;
#(
  parameter int unsigned WORD_W = BYTE_W * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              emit_hi,
  input  logic              emit_lo,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_fire
);

  localparam int unsigned HI_LSB = (BYTES_PER_WORD - 1) * BYTE_W;

  logic [WORD_W-1:0] word_q, word_d;

  // Capture the read data only on the cycle it is valid
  always_comb begin
    word_d = word_q;
    if (load) word_d = word_in;
  end

  // Word register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  // Byte select: high byte, then low byte; zero when nothing is offered
  always_comb begin
    // NOTE: default first so no path leaves out_data unassigned (no latch).
    out_data = '0;
    if (emit_hi)      out_data = word_q[HI_LSB +: BYTE_W];
    else if (emit_lo) out_data = word_q[BYTE_W-1:0];
  end

  assign out_valid = emit_hi | emit_lo;
  assign out_fire  = out_valid & out_ready;

endmodule : word_byte_serializer

// File: rtl/result_stream_reader.sv
// Reads a run of words from data memory and streams them out byte-wise.
module result_stream_reader
  import asip_stream_pkg::*;
#(
  parameter int registerSize = 16,
  parameter int addrWidth    = 16,
  parameter int lenWidth     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addrWidth-1:0]  baseAddr,
  input  logic [lenWidth-1:0]   lenWords,
  result_stream_reader_if.master bus,
  output logic                  busy,
  output logic                  done
);

  stream_state_t         state_q, state_d;
  logic [addrWidth-1:0]  addr_q, addr_d;
  logic [addrWidth-1:0]  mem_addr_q, mem_addr_d;
  logic [lenWidth-1:0]   rem_q, rem_d;
  logic [registerSize-1:0] rd_word;
  logic                  out_fire;

  // Next-state and counter updates
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = baseAddr;
          rem_d   = lenWords;
          state_d = (lenWords == '0) ? DONE : READ;
        end
      end
      READ:    state_d = WAIT;
      WAIT:    state_d = SEND_HI;
      SEND_HI: if (out_fire) state_d = SEND_LO;
      SEND_LO: begin
        if (out_fire) begin
          // Address wraps naturally at the counter width
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == lenWidth'(1)) ? DONE : READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // memAddr is loaded on entry to READ and otherwise holds its last value
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (state_d == READ) mem_addr_d = addr_d;
  end

  // State, counters and address register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign rd_word     = bus.memRdData;
  assign bus.memRdEn = (state_q == READ);
  assign bus.memAddr = mem_addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  word_byte_serializer #(
    .WORD_W (registerSize)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == WAIT),
    .word_in   (rd_word),
    .emit_hi   (state_q == SEND_HI),
    .emit_lo   (state_q == SEND_LO),
    .out_ready (bus.outReady),
    .out_valid (bus.outValid),
    .out_data  (bus.outData),
    .out_fire  (out_fire)
  );

endmodule : result_stream_reader

// File: tb/tb_result_stream_reader.sv
// Directed bench with a byte/address scoreboard for result_stream_reader.
module tb_result_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] baseAddr;
  logic [15:0] lenWords;
  logic        busy;
  logic        done;

  result_stream_reader_if bus ();

  result_stream_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .baseAddr (baseAddr),
    .lenWords (lenWords),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int c0    = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int hs_cnt = 0;
  int rd_cnt = 0;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] addr_q [$];
  logic [7:0]  byte_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.memRdEn)
      bus.memRdData <= mem.exists(bus.memAddr) ? mem[bus.memAddr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare reads and accepted bytes against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.memRdEn) begin
        rd_cnt++;
        check("rd_expected", 32'(addr_q.size() != 0), 32'(1));
        if (addr_q.size() != 0) check("mem_addr", 32'(bus.memAddr), 32'(addr_q.pop_front()));
      end
      if (bus.outValid && bus.outReady) begin
        hs_cnt++;
        check("byte_expected", 32'(byte_q.size() != 0), 32'(1));
        if (byte_q.size() != 0) check("out_byte", 32'(bus.outData), 32'(byte_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic expect_word(input logic [15:0] a, input logic [15:0] w);
    mem[a] = w;
    addr_q.push_back(a);
    byte_q.push_back(w[15:8]);
    byte_q.push_back(w[7:0]);
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    @(negedge clk);
    start = 1'b1; baseAddr = b; lenWords = l;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_no_timeout"}, 32'(done_cnt != d0), 32'(1));
    @(negedge clk);
    @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy), 32'(0));
    check({tag, "_one_done"}, 32'(done_cnt - d0), 32'(1));
    check({tag, "_bytes_drained"}, 32'(byte_q.size()), 32'(0));
    check({tag, "_reads_drained"}, 32'(addr_q.size()), 32'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_memRdEn"}, 32'(bus.memRdEn), 32'(0));
    check({tag, "_memAddr"}, 32'(bus.memAddr), 32'(0));
    check({tag, "_outValid"}, 32'(bus.outValid), 32'(0));
    check({tag, "_outData"}, 32'(bus.outData), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
  endtask

  initial begin
    int d0, h0, r0, n;

    rst = 1'b1; start = 1'b0; baseAddr = '0; lenWords = '0;
    bus.outReady = 1'b1;
    #2;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic transfer: two words, sink always ready
    expect_word(16'h0010, 16'hA1B2);
    expect_word(16'h0011, 16'hC3D4);
    d0 = done_cnt;
    do_start(16'h0010, 16'd2);
    check("basic_busy_t1", 32'(busy), 32'(1));
    check("basic_rden_t1", 32'(bus.memRdEn), 32'(1));
    wait_done("basic", d0, 40);
    check("basic_done_cycle", 32'(last_done_cyc), 32'(c0 + 8));

    // Backpressure: hold the high byte for five cycles
    @(posedge clk); #1 bus.outReady = 1'b0;
    expect_word(16'h0020, 16'h1234);
    d0 = done_cnt; h0 = hs_cnt;
    do_start(16'h0020, 16'd1);
    n = 0;
    while (!bus.outValid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(bus.outValid), 32'(1));
      check("bp_data_held", 32'(bus.outData), 32'h12);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.outReady = 1'b1;
    wait_done("bp", d0, 20);
    check("bp_handshakes", 32'(hs_cnt - h0), 32'(2));

    // Zero length: immediate done, no memory access, no bytes
    d0 = done_cnt; h0 = hs_cnt; r0 = rd_cnt;
    do_start(16'h0030, 16'd0);
    check("zero_done_t1", 32'(done), 32'(1));
    check("zero_no_valid", 32'(bus.outValid), 32'(0));
    wait_done("zero", d0, 5);
    check("zero_no_reads", 32'(rd_cnt - r0), 32'(0));
    check("zero_no_bytes", 32'(hs_cnt - h0), 32'(0));

    // Address wrap from 0xFFFF to 0x0000
    expect_word(16'hFFFF, 16'hBEEF);
    expect_word(16'h0000, 16'h0102);
    d0 = done_cnt; h0 = hs_cnt;
    do_start(16'hFFFF, 16'd2);
    wait_done("wrap", d0, 40);
    check("wrap_bytes", 32'(hs_cnt - h0), 32'(4));

    // A second start while busy must be ignored
    expect_word(16'h0040, 16'h5566);
    expect_word(16'h0041, 16'h7788);
    mem[16'h0080] = 16'hFFEE;
    d0 = done_cnt; h0 = hs_cnt;
    do_start(16'h0040, 16'd2);
    repeat (2) @(negedge clk);
    start = 1'b1; baseAddr = 16'h0080; lenWords = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", d0, 40);
    check("busy_start_bytes", 32'(hs_cnt - h0), 32'(4));

    // Reset during the low byte of word 1 of 3
    expect_word(16'h0050, 16'h0A0B);
    expect_word(16'h0051, 16'h0C0D);
    expect_word(16'h0052, 16'h0E0F);
    d0 = done_cnt; h0 = hs_cnt;
    do_start(16'h0050, 16'd3);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bus.outValid && hs_cnt == h0 + 1) && n < 20);
    check("rst_reached_lo", 32'(bus.outData), 32'h0B);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    addr_q.delete();
    byte_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'(0));
    expect_word(16'h0050, 16'h0A0B);
    expect_word(16'h0051, 16'h0C0D);
    expect_word(16'h0052, 16'h0E0F);
    d0 = done_cnt; h0 = hs_cnt;
    do_start(16'h0050, 16'd3);
    wait_done("after_rst", d0, 60);
    check("after_rst_done_cycle", 32'(last_done_cyc), 32'(c0 + 12));
    check("after_rst_bytes", 32'(hs_cnt - h0), 32'(6));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_result_stream_reader

// File: doc/result_stream_reader.md
# result_stream_reader

Read-side companion to the vector ASIP's data memory. After the processor has written results through its write-back stage, this block reads a contiguous run of 16-bit words from the memory's read port and serializes each word into two bytes, MSB first, on a valid/ready byte stream toward the host/output link. It is a host-facing peripheral sitting beside the processor on the data memory's second port. It never writes memory.

## Interface
Parameters:
- `registerSize`, 16: memory word width; must be 16 (two bytes per word).
- `addrWidth`, 16: memory address width.
- `lenWidth`, 16: width of the word-count field.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a transfer; sampled only in IDLE.
- `baseAddr`  in  addrWidth  first word address; captured on accepted start.
- `lenWords`  in  lenWidth  number of words to send; captured on accepted start.
- `memRdEn`  out  1  memory read strobe.
- `memAddr`  out  addrWidth  memory read address.
- `memRdData`  in  registerSize  read data, valid exactly 1 cycle after `memRdEn`.
- `outValid`  out  1  `outData` holds a valid byte.
- `outReady`  in  1  sink accepts the byte this cycle.
- `outData`  out  8  stream byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the transfer completes.

## Operation
- FSM states: IDLE, READ, WAIT, SEND_HI, SEND_LO, DONE.
- IDLE: on `start`=1, capture `baseAddr` into the address counter and `lenWords` into the remaining counter.
  - If `lenWords`≠0, go to READ.
  - If `lenWords`=0, go straight to DONE.
- READ: `memRdEn`=1, `memAddr`=address counter; go to WAIT.
- WAIT: capture `memRdData` into the word register at the end of the cycle; go to SEND_HI.
- SEND_HI: `outValid`=1, `outData`=word[15:8]. On `outValid`&&`outReady`, go to SEND_LO.
- SEND_LO: `outValid`=1, `outData`=word[7:0]. On handshake, decrement remaining and increment address.
  - If the pre-decrement remaining was 1, go to DONE.
  - Otherwise go to READ.
- DONE: `done`=1 for one cycle; go to IDLE.
- Handshake rules:
  - While `outValid`=1 and `outReady`=0, `outData` and state are held stable.
  - `outValid` never drops without a handshake.
  - `outReady` is ignored when `outValid`=0.
- `start` outside IDLE is ignored; it neither restarts nor queues a transfer.
- Address counter wraps modulo 2^addrWidth (0xFFFF+1 → 0x0000). No error is flagged.
- `lenWords`=2^lenWidth−1 is legal. The remaining counter never underflows.
- Reset mid-transfer: all state is abandoned and the FSM returns to IDLE. Any in-flight byte is lost, and no `done` pulse is produced.

## Timing
- Reset values: `memRdEn`=0, `memAddr`=0, `outValid`=0, `outData`=0, `busy`=0, `done`=0. FSM=IDLE; counters and word register are 0.
- `start` accepted at edge t:
  - READ during cycle t+1 (`memRdEn`=1).
  - WAIT during t+2 (`memRdData` valid).
  - First byte `outValid`=1 from t+3.
- With `outReady` tied high, each word takes 4 cycles: READ, WAIT, SEND_HI, SEND_LO. N words take 4N cycles, and `done` is high in cycle t+1+4N.
- `lenWords`=0: `done` is high in cycle t+1, with no memory access.
- `busy` rises in the cycle after start acceptance and falls in the cycle after DONE.
- `memAddr` holds its last value outside READ; only `memRdEn` qualifies it.

## Structure
- Shared package `asip_stream_pkg` holds:
  - the `stream_state_t` enum (IDLE..DONE);
  - the `BYTE_W`=8 constant;
  - the `BYTES_PER_WORD`=2 constant.
- One natural sub-module is `word_byte_serializer`: it holds the word register plus the HI/LO byte select, exposing valid/ready toward the sink. The FSM and counters stay in `result_stream_reader`.
- No other hierarchy is needed.

## Test plan
- Basic transfer: base=0x0010, len=2, memory {0x0010:0xA1B2, 0x0011:0xC3D4}, `outReady`=1. Required response:
  - bytes A1, B2, C3, D4;
  - `memAddr` 0x0010 then 0x0011;
  - `done` at start+9.
- Backpressure: len=1 word 0x1234, `outReady` low for 5 cycles during SEND_HI. Required response:
  - `outData`=0x12 held stable with `outValid`=1 throughout;
  - then 0x34;
  - exactly 2 handshakes.
- Zero length: `start` with len=0. Required response:
  - `memRdEn` never asserted;
  - `done` pulse 1 cycle after start;
  - `outValid` stays 0.
- Address wrap: base=0xFFFF, len=2. Required response:
  - `memAddr` sequence 0xFFFF, 0x0000;
  - 4 bytes emitted.
- Start while busy: second `start` with different base/len mid-transfer. Required response:
  - ignored; original transfer completes unchanged;
  - single `done`.
- Reset mid-transfer: assert `rst` during SEND_LO of word 1 of 3. Required response:
  - all outputs return to reset values immediately;
  - no `done`;
  - a fresh `start` then runs a full transfer correctly.
